div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Iterative RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU) beside the execute stage ALU.
- Accepts one operation from the E stage and holds the pipeline via a stall output while it runs a 1-bit-per-cycle restoring division.
- Returns a registered result with a one-cycle done pulse.
- Divide-by-zero and signed overflow complete early with RISC-V-mandated results.

Parameters:
- DATA_W, 32: operand/result width. Only 32 is supported.
- CNT_W, 5: iteration counter width. Equals log2(DATA_W).

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  synchronous active-high reset.
- E_start_i  input  1  E stage holds a valid divide-class instruction.
- E_funct3_i  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; any other value treated as DIVU.
- E_val1_i  input  32  dividend (rs1).
- E_val2_i  input  32  divisor (rs2).
- flush_i  input  1  pipeline flush; aborts any operation.
- e_stall_o  output  1  hold F/D/E stages this cycle.
- e_done_o  output  1  one-cycle pulse; e_divE_o is valid.
- e_divE_o  output  32  quotient or remainder, registered.

Behaviour:
- Reset:
  - rst_i high at an edge → state IDLE, counter 0, all internal registers 0, e_divE_o=0, e_done_o=0.
  - Takes effect from any state, including mid-CALC. No done pulse is produced for the aborted operation.
- States: IDLE, CALC, SIGN, DONE. Encoding is free; e_done_o and e_stall_o are decoded from state, not registered separately.
- IDLE:
  - Start: E_start_i=1 and flush_i=0 at an edge. Latch funct3.
  - Latch magnitudes |val1| and |val2| for DIV/REM; raw values for DIVU/REMU.
  - Latch quotient sign = sign1 XOR sign2 and remainder sign = sign1 (signed ops only).
  - Clear the remainder accumulator and counter.
  - Divisor==0 → go directly to DONE. Result is 0xFFFFFFFF for DIV/DIVU; val1 for REM/REMU.
  - Signed op with val1=0x80000000 and val2=0xFFFFFFFF → go directly to DONE. Result is 0x80000000 for DIV; 0 for REM.
  - Otherwise go to CALC.
- CALC:
  - One restoring step per edge: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient LSB if no borrow.
  - The counter increments each step. After the step with counter==31, go to SIGN. CALC lasts exactly 32 cycles.
- SIGN: negate the quotient if its sign bit is set, negate the remainder if its sign bit is set, select the output by funct3, load e_divE_o, go to DONE.
- DONE: e_done_o=1 for exactly this cycle; e_divE_o holds the result. Next state is always IDLE; E_start_i is ignored in DONE.
- e_divE_o holds its value until the next DONE load or reset. It does not change during IDLE/CALC/SIGN.
- Stall: e_stall_o = (IDLE & E_start_i & ~flush_i) | CALC | SIGN.
  - Low in DONE, so the pipeline advances on the same edge that e_done_o is sampled.
- Latency, normal op: start sampled at edge 0 → CALC cycles 1–32, SIGN cycle 33, DONE cycle 34. That is 34 stall cycles.
- Latency, special case: DONE in cycle 1, 1 stall cycle.
- Back-to-back: E_start_i high in the IDLE cycle right after DONE starts a new operation with no bubble beyond that IDLE cycle.
- flush_i:
  - In IDLE: start is blocked.
  - In CALC/SIGN: go to IDLE next edge; no e_done_o; e_divE_o keeps its old value; e_stall_o=0 in the flush cycle.
  - In DONE: the pulse still completes.
- Operand or funct3 changes after start have no effect; all values are latched at start.
- rst_i has priority over flush_i, which has priority over start.

Test Plan:
- DIVU 100/7 → e_stall_o high 34 cycles, e_done_o at cycle 34, e_divE_o=14. REMU same operands → 2.
- DIV 0xFFFFFFF9(−7)/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). REM 7/−2 → 1.
- DIV 5/0 → done at cycle 1, result 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Two back-to-back DIVU (0xFFFFFFFF/1 then 9/3) → results 0xFFFFFFFF then 3, each with one done pulse, separated by one IDLE cycle.
- DIVU 1000/10 with flush_i at cycle 10 → IDLE at cycle 11, no done pulse, e_divE_o unchanged. Next DIVU 8/2 → 4.
- rst_i at cycle 20 of a DIV → e_divE_o=0, e_stall_o=0, e_done_o never pulses. A following DIV 20/4 → 5 at normal latency.

Source files
------------

// File: rtl/div_seq.sv
// Iterative RV32M divide/remainder unit: one restoring step per cycle,
// stalls the E stage while busy and returns a registered result with a done pulse.
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              E_start_i,
  input  logic [2:0]        E_funct3_i,
  input  logic [DATA_W-1:0] E_val1_i,
  input  logic [DATA_W-1:0] E_val2_i,
  input  logic              flush_i,
  output logic              e_stall_o,
  output logic              e_done_o,
  output logic [DATA_W-1:0] e_divE_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W-1:0] r_res;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_rem;
  logic              r_qsign;
  logic              r_rsign;

  logic              w_start;
  logic              w_signed_in;
  logic              w_rem_in;
  logic              w_sign1;
  logic              w_sign2;
  logic              w_div0;
  logic              w_ovf;
  logic [DATA_W-1:0] w_abs1;
  logic [DATA_W-1:0] w_abs2;
  logic [DATA_W-1:0] w_special_res;
  logic [DATA_W:0]   w_shift;
  logic              w_ge;
  logic [DATA_W-1:0] w_sub;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;

  // Operand decode; only 100 (DIV) and 110 (REM) are signed, all other codes act unsigned.
  assign w_start       = (r_state == S_IDLE) && E_start_i && !flush_i;
  assign w_signed_in   = (E_funct3_i == 3'b100) || (E_funct3_i == 3'b110);
  assign w_rem_in      = (E_funct3_i == 3'b110) || (E_funct3_i == 3'b111);
  assign w_sign1       = w_signed_in && E_val1_i[DATA_W-1];
  assign w_sign2       = w_signed_in && E_val2_i[DATA_W-1];
  assign w_abs1        = w_sign1 ? -E_val1_i : E_val1_i;
  assign w_abs2        = w_sign2 ? -E_val2_i : E_val2_i;
  assign w_div0        = (E_val2_i == '0);
  assign w_ovf         = w_signed_in && (E_val1_i == MIN_NEG) && (E_val2_i == '1);
  assign w_special_res = w_div0 ? (w_rem_in ? E_val1_i : '1)
                                : (w_rem_in ? '0 : MIN_NEG);

  // Restoring step: the shifted partial remainder needs one extra bit for the compare.
  assign w_shift   = {r_rem, r_quo[DATA_W-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_sub     = w_shift[DATA_W-1:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_sub : w_shift[DATA_W-1:0];
  assign w_quo_fix = r_qsign ? -r_quo : r_quo;
  assign w_rem_fix = r_rsign ? -r_rem : r_rem;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    e_stall_o = 1'b0;
    e_done_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        e_stall_o = w_start;
        if (w_start) w_next = (w_div0 || w_ovf) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        e_stall_o = !flush_i;
        if (flush_i)                        w_next = S_IDLE;
        else if (r_cnt == {CNT_W{1'b1}})    w_next = S_SIGN;
      end
      S_SIGN: begin
        e_stall_o = !flush_i;
        w_next    = flush_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        e_done_o = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_is_rem <= 1'b0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_quo    <= w_abs1;
            r_dvs    <= w_abs2;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_is_rem <= w_rem_in;
            r_qsign  <= w_sign1 ^ w_sign2;
            r_rsign  <= w_sign1;
            if (w_div0 || w_ovf) r_res <= w_special_res;
          end
        end
        S_CALC: begin
          if (!flush_i) begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SIGN: begin
          if (!flush_i) r_res <= r_is_rem ? w_rem_fix : w_quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign e_divE_o = r_res;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus random operations checked
// against an arithmetic reference model, with latency, stall and pulse checks.
module tb_div_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        E_start_i;
  logic [2:0]  E_funct3_i;
  logic [31:0] E_val1_i;
  logic [31:0] E_val2_i;
  logic        flush_i;
  logic        e_stall_o;
  logic        e_done_o;
  logic [31:0] e_divE_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  div_seq dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .E_start_i  (E_start_i),
    .E_funct3_i (E_funct3_i),
    .E_val1_i   (E_val1_i),
    .E_val2_i   (E_val2_i),
    .flush_i    (flush_i),
    .e_stall_o  (e_stall_o),
    .e_done_o   (e_done_o),
    .e_divE_o   (e_divE_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M semantics using the simulator's own division (truncates toward zero).
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    bit rem;
    int sa;
    int sb;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    rem = (f3 == 3'b110) || (f3 == 3'b111);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
      sa = int'(a);
      sb = int'(b);
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? (a % b) : (a / b);
  endfunction

  // Runs one operation starting in the current cycle; returns at the negedge of the
  // IDLE cycle following DONE (or after 40 cycles for aborted operations).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int rst_at);
    logic [31:0] exp_v;
    bit          special;
    bit          aborts;
    bit          held;
    int          stalls;
    int          dones;
    int          done_at;
    int          lat;
    exp_v   = ref_div(f3, a, b);
    special = is_special(f3, a, b);
    aborts  = (rst_at >= 0) || (flush_at >= 1 && flush_at < (special ? 1 : 34));
    held    = 1'b1;
    stalls  = 0;
    dones   = 0;
    done_at = -1;
    lat     = special ? 1 : 34;
    if (!aborts) exp_q.push_back(exp_v);
    for (int c = 0; c < 40; c++) begin
      E_start_i = (c == 0);
      if (c == 0) begin
        E_funct3_i = f3;
        E_val1_i   = a;
        E_val2_i   = b;
      end else begin
        E_funct3_i = 3'($urandom);
        E_val1_i   = $urandom;
        E_val2_i   = $urandom;
      end
      flush_i = (c == flush_at);
      rst_i   = (c == rst_at);
      #1;
      if (e_stall_o) stalls++;
      if (e_done_o) begin
        dones++;
        done_at = c;
        if (exp_q.size() > 0) check_eq("result", e_divE_o, exp_q.pop_front());
      end else if (done_at < 0 && e_divE_o !== last_res) begin
        held = 1'b0;
      end
      @(negedge clk_i);
      if (!aborts && done_at >= 0) break;
    end
    E_start_i = 1'b0;
    flush_i   = 1'b0;
    rst_i     = 1'b0;
    check_eq("done_count", dones, aborts ? 0 : 1);
    if (aborts) begin
      check_eq("abort_stalls", stalls, (rst_at >= 0) ? rst_at + 1 : flush_at);
      if (rst_at >= 0) begin
        check_eq("reset_result", e_divE_o, 32'd0);
        last_res = 32'd0;
      end else begin
        check_eq("flush_hold", held, 1);
        check_eq("flush_result", e_divE_o, last_res);
      end
      check_eq("idle_stall", e_stall_o, 0);
    end else begin
      if (dones == 0) exp_q.delete();
      check_eq("done_cycle", done_at, lat);
      check_eq("stall_cycles", stalls, lat);
      check_eq("hold_before_done", held, 1);
      check_eq("result_after_done", e_divE_o, exp_v);
      last_res = exp_v;
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          mode;
    rst_i      = 1'b1;
    E_start_i  = 1'b0;
    flush_i    = 1'b0;
    E_funct3_i = 3'b000;
    E_val1_i   = 32'd0;
    E_val2_i   = 32'd0;
    last_res   = 32'd0;
    repeat (3) @(negedge clk_i);
    #1;
    check_eq("reset_stall", e_stall_o, 0);
    check_eq("reset_done", e_done_o, 0);
    check_eq("reset_result", e_divE_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_op(3'b101, 32'd100, 32'd7, -1, -1);
    run_op(3'b111, 32'd100, 32'd7, -1, -1);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, -1, -1);
    run_op(3'b100, 32'd5, 32'd0, -1, -1);
    run_op(3'b111, 32'd5, 32'd0, -1, -1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, -1, -1);
    run_op(3'b101, 32'd9, 32'd3, -1, -1);
    run_op(3'b101, 32'd1000, 32'd10, 10, -1);
    run_op(3'b101, 32'd8, 32'd2, -1, -1);
    run_op(3'b100, 32'd12345, 32'd77, -1, 20);
    run_op(3'b100, 32'd20, 32'd4, -1, -1);
    run_op(3'b100, 32'd77, 32'd5, 34, -1);
    run_op(3'b010, 32'd50, 32'd6, -1, -1);
    @(negedge clk_i);

    for (int i = 0; i < 24; i++) begin
      f3   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 5);
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3: b = 32'($urandom_range(1, 255)) | (b & 32'h8000_0000);
        default: ;
      endcase
      run_op(f3, a, b, -1, -1);
      if ($urandom_range(0, 1) == 1) @(negedge clk_i);
    end

    check_eq("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
